// File: rtl/ycbcr444_to_rgb565.sv
// ---------------------------------------------------------------------------
// ycbcr444_to_rgb565
//
// Three-stage pipelined YCbCr 4:4:4 to RGB565 converter. It undoes the
// front-end RGB565 -> YCbCr stage so that processed luma/chroma can go back
// to the LCD domain. One pixel is accepted every clock. There is no
// handshake, and no state is carried from one pixel to the next.
//
// Optional feature macro: YCBCR2RGB_ROUND_EN
//   defined   : 128 is added to each sum before the >>8, so every 8-bit
//               channel is rounded half-up.
//   undefined : each 8-bit channel is floored.
// The 565 packing always truncates. Latency is the same in both builds.
//
// Parameters
//   H_DISP, V_DISP   Frame geometry. Informational only.
//
// Ports
//   clk          in   1   pixel clock
//   rst          in   1   asynchronous, active-high reset
//   ycbcr_hsync  in   1   line sync
//   ycbcr_vsync  in   1   frame sync
//   ycbcr_de     in   1   data enable
//   ycbcr_data   in  24   {Y, Cb, Cr}, each unsigned 8-bit
//   rgb_hsync    out  1   ycbcr_hsync delayed 3 cycles
//   rgb_vsync    out  1   ycbcr_vsync delayed 3 cycles
//   rgb_de       out  1   ycbcr_de delayed 3 cycles
//   rgb_data     out 16   {R[4:0], G[5:0], B[4:0]}, zero while rgb_de is low
// ---------------------------------------------------------------------------
module ycbcr444_to_rgb565 #(
  parameter logic [11:0] H_DISP = 12'd480,
  parameter logic [11:0] V_DISP = 12'd272
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ycbcr_hsync,
  input  logic        ycbcr_vsync,
  input  logic        ycbcr_de,
  input  logic [23:0] ycbcr_data,
  output logic        rgb_hsync,
  output logic        rgb_vsync,
  output logic        rgb_de,
  output logic [15:0] rgb_data
);

  // The geometry is kept only to document the frame size. This empty block
  // is the single place that refers to it.
  if (H_DISP == 12'd0 || V_DISP == 12'd0) begin : g_geometry_unset
  end

`ifdef YCBCR2RGB_ROUND_EN
  localparam logic signed [18:0] ROUND_C = 19'sd128;
`else
  localparam logic signed [18:0] ROUND_C = 19'sd0;
`endif

  // Every accumulator is 19-bit signed. The largest magnitude is below 2^17,
  // so no intermediate value can overflow.
  logic signed [18:0] cb_off;
  logic signed [18:0] cr_off;

  logic signed [18:0] y_s1;
  logic signed [18:0] r_cr_s1;
  logic signed [18:0] g_cb_s1;
  logic signed [18:0] g_cr_s1;
  logic signed [18:0] b_cb_s1;

  logic signed [18:0] r_s2;
  logic signed [18:0] g_s2;
  logic signed [18:0] b_s2;

  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] rgb_next;

  logic [2:0] hs_sr;
  logic [2:0] vs_sr;
  logic [2:0] de_sr;

  // Chroma is recentred to -128..127.
  assign cb_off = $signed({11'd0, ycbcr_data[15:8]}) - 19'sd128;
  assign cr_off = $signed({11'd0, ycbcr_data[7:0]})  - 19'sd128;

  // Stage 1 registers Y*256 and the four coefficient products (x256 scale).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_s1    <= '0;
      r_cr_s1 <= '0;
      g_cb_s1 <= '0;
      g_cr_s1 <= '0;
      b_cb_s1 <= '0;
    end else begin
      y_s1    <= $signed({3'd0, ycbcr_data[23:16], 8'd0});
      r_cr_s1 <= 19'sd359 * cr_off;
      g_cb_s1 <= 19'sd88  * cb_off;
      g_cr_s1 <= 19'sd183 * cr_off;
      b_cb_s1 <= 19'sd454 * cb_off;
    end
  end

  // Stage 2 registers the three channel sums. ROUND_C is added here so that
  // the rounded build has the same latency as the truncating build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2 <= '0;
      g_s2 <= '0;
      b_s2 <= '0;
    end else begin
      r_s2 <= y_s1 + r_cr_s1 + ROUND_C;
      g_s2 <= y_s1 - g_cb_s1 - g_cr_s1 + ROUND_C;
      b_s2 <= y_s1 + b_cb_s1 + ROUND_C;
    end
  end

  // The arithmetic shift floors, so anything in -1..-0.x lands on -1 and
  // clamps to 0. Anything at or above 256 clamps to 255.
  function automatic logic [7:0] clamp_u8(input logic signed [18:0] acc);
    logic signed [18:0] shifted;
    shifted = acc >>> 8;
    if (shifted < 19'sd0)
      clamp_u8 = 8'd0;
    else if (shifted > 19'sd255)
      clamp_u8 = 8'hFF;
    else
      clamp_u8 = shifted[7:0];
  endfunction

  // The low bits are masked rather than sliced away. This drops them in the
  // same way that truncation to 5/6/5 would.
  always_comb begin
    r8       = clamp_u8(r_s2);
    g8       = clamp_u8(g_s2);
    b8       = clamp_u8(b_s2);
    rgb_next = ({8'd0, r8 & 8'hF8} << 8)
             | ({8'd0, g8 & 8'hFC} << 3)
             | ({8'd0, b8} >> 3);
  end

  // Stage 3 output register. de_sr[1] is the enable that moves to rgb_de on
  // this same edge, so blanking stays aligned with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rgb_data <= '0;
    else if (de_sr[1])
      rgb_data <= rgb_next;
    else
      rgb_data <= '0;
  end

  // Timing signals pass through unchanged, 3 cycles deep to match the data path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[1:0], ycbcr_hsync};
      vs_sr <= {vs_sr[1:0], ycbcr_vsync};
      de_sr <= {de_sr[1:0], ycbcr_de};
    end
  end

  assign rgb_hsync = hs_sr[2];
  assign rgb_vsync = vs_sr[2];
  assign rgb_de    = de_sr[2];

endmodule

// File: tb/tb_ycbcr444_to_rgb565.sv
// ---------------------------------------------------------------------------
// tb_ycbcr444_to_rgb565
//
// Directed bench for ycbcr444_to_rgb565. The expected RGB565 words were
// worked out by hand from the conversion equations. Where the two builds
// differ, YCBCR2RGB_ROUND_EN selects the expected word.
// ---------------------------------------------------------------------------
module tb_ycbcr444_to_rgb565;

  logic        clk;
  logic        rst;
  logic        ycbcr_hsync;
  logic        ycbcr_vsync;
  logic        ycbcr_de;
  logic [23:0] ycbcr_data;
  logic        rgb_hsync;
  logic        rgb_vsync;
  logic        rgb_de;
  logic [15:0] rgb_data;

  int checks;
  int failures;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic [15:0] exp_rgb;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  ycbcr444_to_rgb565 dut (
    .clk         (clk),
    .rst         (rst),
    .ycbcr_hsync (ycbcr_hsync),
    .ycbcr_vsync (ycbcr_vsync),
    .ycbcr_de    (ycbcr_de),
    .ycbcr_data  (ycbcr_data),
    .rgb_hsync   (rgb_hsync),
    .rgb_vsync   (rgb_vsync),
    .rgb_de      (rgb_de),
    .rgb_data    (rgb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This is the only comparison point. It counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change only on the falling edge, well away from the capturing edge.
  task automatic applyStimulus(input logic hs, input logic vs, input logic de,
                               input logic [7:0] y, input logic [7:0] cb,
                               input logic [7:0] cr);
    ycbcr_hsync = hs;
    ycbcr_vsync = vs;
    ycbcr_de    = de;
    ycbcr_data  = {y, cb, cr};
  endtask

  function automatic vec_t mk(input logic hs, input logic vs, input logic de,
                              input logic [7:0] y, input logic [7:0] cb,
                              input logic [7:0] cr, input logic [15:0] e);
    vec_t v;
    v.hs = hs; v.vs = vs; v.de = de;
    v.y = y; v.cb = cb; v.cr = cr;
    v.exp_rgb = e;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    // Mid grey, which is the same in both builds.
    vecs[0]  = mk(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128, 16'h8410);
    // R overflows and clamps to 255.
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 8'd255, 8'd128, 8'd255, 16'hFD3F);
    // B goes negative and clamps to 0.
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   8'd128, 16'h0160);
`ifdef YCBCR2RGB_ROUND_EN
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 8'd130, 8'd128, 8'd132, 16'h8BF0);
`else
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 8'd130, 8'd128, 8'd132, 16'h83F0);
`endif
    // White followed directly by black.
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 8'd255, 8'd128, 8'd128, 16'hFFFF);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 8'd0,   8'd128, 8'd128, 16'h0000);
    // Blanking: a bright pixel with de low must come out as zero.
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 8'd255, 8'd128, 8'd128, 16'h0000);
`ifdef YCBCR2RGB_ROUND_EN
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'd0,   8'd255, 8'd0,   16'h019C);
`else
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'd0,   8'd255, 8'd0,   16'h017C);
`endif
    // de toggling: the same pixel, first blanked and then shown.
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 8'd16,  8'd128, 8'd128, 16'h0000);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 8'd16,  8'd128, 8'd128, 16'h1082);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 8'd235, 8'd16,  8'd240, 16'hFE04);
    // B lands at 256.x and saturates to 255 exactly.
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 8'd255, 8'd129, 8'd128, 16'hFFFF);

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    #1;
    checkOutput("reset_data", {16'd0, rgb_data}, 32'd0);
    checkOutput("reset_syncs", {29'd0, rgb_hsync, rgb_vsync, rgb_de}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // A vector driven on negedge i shows up at negedge i+3.
    for (int i = 0; i < NVEC + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checkOutput($sformatf("v%0d_data", i - 3), {16'd0, rgb_data},
                    {16'd0, vecs[i-3].exp_rgb});
        checkOutput($sformatf("v%0d_de", i - 3), {31'd0, rgb_de},
                    {31'd0, vecs[i-3].de});
        checkOutput($sformatf("v%0d_hsync", i - 3), {31'd0, rgb_hsync},
                    {31'd0, vecs[i-3].hs});
        checkOutput($sformatf("v%0d_vsync", i - 3), {31'd0, rgb_vsync},
                    {31'd0, vecs[i-3].vs});
      end
      if (i < NVEC)
        applyStimulus(vecs[i].hs, vecs[i].vs, vecs[i].de,
                      vecs[i].y, vecs[i].cb, vecs[i].cr);
      else
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    end

    // Reset in the middle of the stream. Fill the pipe with white first.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128);
    repeat (4) @(negedge clk);
    checkOutput("prereset_data", {16'd0, rgb_data}, 32'h0000FFFF);
    checkOutput("prereset_syncs", {29'd0, rgb_hsync, rgb_vsync, rgb_de}, 32'd7);

    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_data", {16'd0, rgb_data}, 32'd0);
    checkOutput("midreset_syncs", {29'd0, rgb_hsync, rgb_vsync, rgb_de}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // The release cycle and the next two cycles still show the flushed pipe.
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("postreset%0d_data", k), {16'd0, rgb_data}, 32'd0);
      checkOutput($sformatf("postreset%0d_syncs", k),
                  {29'd0, rgb_hsync, rgb_vsync, rgb_de}, 32'd0);
    end
    @(negedge clk);
    checkOutput("resume_data", {16'd0, rgb_data}, 32'h0000FFFF);
    checkOutput("resume_syncs", {29'd0, rgb_hsync, rgb_vsync, rgb_de}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
